// File: rtl/eth_capture_ctrl.sv
// eth_capture_ctrl: writes samples into a ping-pong buffer and hands each filled half to the
// Ethernet transmitter in fill order, flushing a partial half when the session stops.
module eth_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              tx_req,
    output logic [ADDR_W-1:0] tx_base,
    output logic [ADDR_W-1:0] tx_len,
    input  logic              tx_ack,
    input  logic              tx_done,
    output logic              busy,
    output logic              overflow,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
);
    localparam logic [ADDR_W-1:0] HALF = ADDR_W'(2 ** (ADDR_W - 1));

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

    state_t                   state, state_n;
    logic                     wr_half, tx_ptr, in_flight;
    logic [ADDR_W-2:0]        wr_cnt;
    logic [1:0]               full, full_set, full_clr;
    logic [1:0][ADDR_W-1:0]   len;
    logic                     enter, capture, accept, drop, wrap, flush_part;
    logic                     launch, acked, retire, drained;

    always_comb begin
        enter      = (state == IDLE) && start;
        capture    = (state == CAPTURE) && !stop;
        accept     = capture && sample_valid && !full[wr_half];
        drop       = capture && sample_valid && full[wr_half];
        wrap       = accept && (&wr_cnt);
        flush_part = (state == CAPTURE) && stop && (wr_cnt != '0);
        launch     = (state != IDLE) && !tx_req && !in_flight && full[tx_ptr];
        acked      = tx_req && tx_ack;
        retire     = in_flight && tx_done;
        drained    = (full == 2'b00) && !in_flight && !tx_req;
        full_set   = (wrap || flush_part) ? (2'b01 << wr_half) : 2'b00;
        full_clr   = retire ? (2'b01 << tx_ptr) : 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = enter                                 ? CAPTURE :
                  ((state == CAPTURE) && stop)          ? FLUSH   :
                  ((state == FLUSH) && drained)         ? IDLE    : state;
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_we    <= 1'b0;
            buf_waddr <= '0;
            buf_wdata <= '0;
            tx_req    <= 1'b0;
            tx_base   <= '0;
            tx_len    <= '0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
            wr_half   <= 1'b0;
            wr_cnt    <= '0;
            tx_ptr    <= 1'b0;
            full      <= 2'b00;
            len       <= '0;
            in_flight <= 1'b0;
        end else begin
            buf_we <= accept;
            if (accept) begin
                buf_waddr <= {wr_half, wr_cnt};
                buf_wdata <= sample_data;
                wr_cnt    <= wr_cnt + (ADDR_W-1)'(1);
            end
            if (wrap)
                wr_half <= ~wr_half;
            if (wrap || flush_part)
                len[wr_half] <= wrap ? HALF : {1'b0, wr_cnt};
            full <= (full & ~full_clr) | full_set;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
            if (launch) begin
                tx_req  <= 1'b1;
                tx_base <= {tx_ptr, {(ADDR_W-1){1'b0}}};
                tx_len  <= len[tx_ptr];
            end else if (acked) begin
                tx_req    <= 1'b0;
                in_flight <= 1'b1;
            end
            if (retire) begin
                in_flight <= 1'b0;
                tx_ptr    <= ~tx_ptr;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (enter) begin
                wr_half   <= 1'b0;
                wr_cnt    <= '0;
                tx_ptr    <= 1'b0;
                frame_cnt <= '0;
                drop_cnt  <= '0;
                overflow  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_eth_capture_ctrl.sv
// tb_eth_capture_ctrl: scoreboard bench; buffer writes and frame requests are checked by
// independent monitor/responder processes against queues filled by the stimulus.
module tb_eth_capture_ctrl;
    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          tx_ack = 1'b0;
    logic          tx_done = 1'b0;
    logic          buf_we, tx_req, busy, overflow;
    logic [AW-1:0] buf_waddr, tx_base, tx_len;
    logic [DW-1:0] buf_wdata;
    logic [15:0]   frame_cnt, drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [AW+DW-1:0] wrq[$];
    logic [2*AW-1:0]  txq[$];
    bit               ack_en = 1'b0;
    int               done_delay = 1;
    int               dcount = -1;
    bit               seen = 1'b0;
    logic [2*AW-1:0]  cur_tx;
    logic [AW+DW-1:0] cur_wr;

    eth_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .tx_req(tx_req), .tx_base(tx_base), .tx_len(tx_len),
        .tx_ack(tx_ack), .tx_done(tx_done), .busy(busy), .overflow(overflow),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && buf_we) begin
            if (wrq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h, expected no write", buf_waddr);
            end else begin
                cur_wr = wrq.pop_front();
                chk("wr_addr", 32'(buf_waddr), 32'(cur_wr[AW+DW-1:DW]));
                chk("wr_data", 32'(buf_wdata), 32'(cur_wr[DW-1:0]));
            end
        end
    end

    // Transmitter model: checks each request against the queue, then acks and later signals done.
    initial begin
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (reset) begin
                tx_ack = 1'b0;
                seen   = 1'b0;
                dcount = -1;
            end else begin
                if (tx_req) begin
                    if (!seen) begin
                        if (txq.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_tx: got base %0h len %0h, expected none", tx_base, tx_len);
                            cur_tx = {tx_base, tx_len};
                        end else begin
                            cur_tx = txq.pop_front();
                            chk("tx_base", 32'(tx_base), 32'(cur_tx[2*AW-1:AW]));
                            chk("tx_len", 32'(tx_len), 32'(cur_tx[AW-1:0]));
                        end
                        seen = 1'b1;
                    end else begin
                        chk("tx_hold", 32'({tx_base, tx_len}), 32'(cur_tx));
                    end
                    tx_ack = ack_en;
                    if (ack_en) begin
                        dcount = done_delay;
                        seen   = 1'b0;
                    end
                end else begin
                    tx_ack = 1'b0;
                    seen   = 1'b0;
                end
                if (dcount == 0) begin
                    tx_done = 1'b1;
                    dcount  = -1;
                end else if (dcount > 0) begin
                    dcount--;
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    task automatic stream(input int n, input int n_written);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_data  = i[DW-1:0];
            if (i < n_written)
                wrq.push_back({i[AW-1:0], i[DW-1:0]});
        end
        @(negedge clk) sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (busy && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_frames(input int n, input int lim);
        int k = 0;
        while (frame_cnt != 16'(n) && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("frames_reached", 32'(frame_cnt), 32'(n));
    endtask

    initial begin
        // 1: reset values, idle behaviour, start beating stop
        repeat (3) @(negedge clk);
        chk("rst_buf_we", 32'(buf_we), 32'd0);
        chk("rst_waddr", 32'(buf_waddr), 32'd0);
        chk("rst_wdata", 32'(buf_wdata), 32'd0);
        chk("rst_tx_req", 32'(tx_req), 32'd0);
        chk("rst_tx_base", 32'(tx_base), 32'd0);
        chk("rst_tx_len", 32'(tx_len), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        reset = 1'b0;
        pulse_stop();
        chk("idle_stop_busy", 32'(busy), 32'd0);
        stream(3, 0);
        @(negedge clk);
        chk("idle_no_write", 32'(buf_we), 32'd0);
        @(negedge clk) begin start = 1'b1; stop = 1'b1; end
        @(negedge clk) begin start = 1'b0; stop = 1'b0; end
        chk("start_wins_busy", 32'(busy), 32'd1);
        pulse_stop();
        wait_idle(10);

        // 2: one full half, acked and completed
        ack_en = 1'b1;
        done_delay = 5;
        txq.push_back({10'd0, 10'd512});
        pulse_start();
        stream(512, 512);
        wait_frames(1, 100);
        chk("t2_drop_cnt", 32'(drop_cnt), 32'd0);
        pulse_stop();
        wait_idle(50);

        // 3: transmitter stalled, both halves fill and the tail is dropped
        ack_en = 1'b0;
        txq.push_back({10'd0, 10'd512});
        txq.push_back({10'd512, 10'd512});
        pulse_start();
        chk("t3_frames_cleared", 32'(frame_cnt), 32'd0);
        stream(1100, 1024);
        repeat (3) @(negedge clk);
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd76);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_tx_req", 32'(tx_req), 32'd1);
        chk("t3_tx_base", 32'(tx_base), 32'd0);
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd0);
        ack_en = 1'b1;
        done_delay = 3;
        wait_frames(2, 200);
        pulse_stop();
        wait_idle(50);
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);

        // 4: partial frame flushed on stop; the sample alongside stop is ignored
        txq.push_back({10'd0, 10'd100});
        pulse_start();
        chk("t4_overflow_cleared", 32'(overflow), 32'd0);
        chk("t4_drop_cleared", 32'(drop_cnt), 32'd0);
        stream(100, 100);
        @(negedge clk) begin stop = 1'b1; sample_valid = 1'b1; sample_data = 8'hEE; end
        @(negedge clk) begin stop = 1'b0; sample_valid = 1'b0; end
        chk("t4_flush_busy", 32'(busy), 32'd1);
        wait_idle(100);
        chk("t4_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t4_drop_cnt", 32'(drop_cnt), 32'd0);

        // 5: immediate ack, late done, then a partial second half
        done_delay = 20;
        txq.push_back({10'd0, 10'd512});
        txq.push_back({10'd512, 10'd88});
        pulse_start();
        stream(600, 600);
        pulse_stop();
        wait_idle(200);
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("t5_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);

        // 6: reset with a request pending and samples still arriving
        ack_en = 1'b0;
        txq.push_back({10'd0, 10'd512});
        pulse_start();
        stream(515, 515);
        @(negedge clk) begin sample_valid = 1'b1; sample_data = 8'h55; end
        chk("t6_req_before", 32'(tx_req), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_tx_req", 32'(tx_req), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_buf_we", 32'(buf_we), 32'd0);
        chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("t6_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        sample_valid = 1'b0;
        reset = 1'b0;
        ack_en = 1'b1;
        done_delay = 2;
        txq.push_back({10'd0, 10'd10});
        pulse_start();
        stream(10, 10);
        pulse_stop();
        wait_idle(50);
        chk("t6_new_frame_cnt", 32'(frame_cnt), 32'd1);

        repeat (3) @(negedge clk);
        chk("writes_drained", 32'(wrq.size()), 32'd0);
        chk("tx_drained", 32'(txq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/eth_capture_ctrl.md
Name: eth_capture_ctrl

Overview:
Sequences a capture-and-send session for the Ethernet debug path. Driven by the start/stop pulses of the button state machine, it writes incoming byte samples into a ping-pong sample buffer (two halves of one RAM). It hands each filled half to the Ethernet frame transmitter through a request/ack/done handshake. It flushes a partial frame on stop, and tracks sent frames and dropped samples.

Parameters:
ADDR_W, 10, buffer address width; each half holds HALF = 2^(ADDR_W-1) words (512 by default)
DATA_W, 8, sample / buffer word width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin session
stop  in  1  one-cycle pulse: end session
sample_valid  in  1  sample_data valid this cycle
sample_data  in  DATA_W  sample byte
buf_we  out  1  buffer write enable
buf_waddr  out  ADDR_W  buffer write address
buf_wdata  out  DATA_W  buffer write data
tx_req  out  1  frame send request
tx_base  out  ADDR_W  frame start address (0 or HALF)
tx_len  out  ADDR_W  frame length in words, 1..HALF
tx_ack  in  1  transmitter accepts request
tx_done  in  1  one-cycle pulse: frame fully read out of the buffer
busy  out  1  session active (state != IDLE)
overflow  out  1  sticky: at least one sample dropped this session
frame_cnt  out  16  frames completed this session, wraps
drop_cnt  out  16  samples dropped this session, saturates at 0xFFFF

Behaviour:
- Reset: clk and reset as decided (reset async, active-high). All outputs 0. State IDLE; wr_half=0, wr_cnt=0, tx_ptr=0, full[1:0]=0, in_flight=0.
- States: IDLE, CAPTURE, FLUSH.
- IDLE: start -> CAPTURE. On entry, clear wr_half, wr_cnt, tx_ptr, frame_cnt, drop_cnt, overflow. stop is ignored. start and stop in the same cycle: start wins, stop is ignored.
- CAPTURE:
  - A sample is accepted when sample_valid=1 and full[wr_half]=0.
  - Accepted sample: next cycle buf_we=1, buf_waddr = wr_half*HALF + wr_cnt, buf_wdata = sample_data (latency 1). Then wr_cnt increments.
  - When an accepted sample makes wr_cnt reach HALF: full[wr_half]=1, len[wr_half]=HALF, wr_half toggles, wr_cnt=0.
  - Not accepted (full[wr_half]=1): sample dropped, overflow=1, drop_cnt increments (saturating). No buffer write.
- stop in CAPTURE -> FLUSH.
  - If wr_cnt>0: full[wr_half]=1, len[wr_half]=wr_cnt.
  - If wr_cnt=0: no partial frame.
  - A sample_valid in the same cycle as stop is ignored (not written, not counted as dropped).
- start in CAPTURE or FLUSH: ignored.
- FLUSH: samples ignored. Returns to IDLE when full==0 and in_flight==0 and tx_req==0.
- TX scheduler (runs in CAPTURE and FLUSH):
  - When full[tx_ptr]=1, in_flight=0 and tx_req=0: next cycle tx_req=1, tx_base = tx_ptr*HALF, tx_len = len[tx_ptr].
  - tx_req, tx_base and tx_len hold stable until tx_ack=1 is sampled. Then tx_req=0 in the following cycle and in_flight=1.
  - tx_done while in_flight=1: full[tx_ptr]=0, tx_ptr toggles, in_flight=0, frame_cnt+1. tx_done is ignored when in_flight=0.
  - At most one request or frame outstanding at a time; halves are sent strictly in fill order.
- Same-cycle events: tx_done freeing a half and a sample arriving for that half in the same cycle: the sample is still dropped (full is evaluated pre-update). A half filling and tx_done on the other half in the same cycle: both updates apply.
- Length rule: a stored length of HALF is encoded as HALF; ADDR_W bits are sufficient.
- busy = (state != IDLE), registered with the state.
- Reset mid-session: immediate return to reset values; tx_req drops asynchronously. Any frame in progress is abandoned; the transmitter side is reset by the same signal.

Test Plan:
1. Reset then idle: all outputs 0. stop alone leaves busy=0. sample_valid in IDLE produces no buf_we.
2. start, then 512 consecutive samples (data = index) -> buf_we at addr 0..511, one cycle after each sample. tx_req with tx_base=0, tx_len=512. Ack, then done -> frame_cnt=1.
3. Hold tx_ack=0 and stream 1100 samples -> halves 0 and 1 fill; samples 1025..1100 dropped, drop_cnt=76, overflow=1. tx_req stays high with tx_base=0 throughout.
4. start, 100 samples, stop -> FLUSH. tx_req with tx_base=0, tx_len=100. After ack and done: busy=0, frame_cnt=1.
5. start, 600 samples with tx acking immediately, done 20 cycles after ack, then stop -> two frames (base 0 len 512, then base 512 len 88), frame_cnt=2, drop_cnt=0.
6. Assert reset while tx_req=1 mid-stream -> tx_req=0 at once and all counters 0. A new start works normally.
